// File: rtl/dmem_port_stage.sv
// Data-memory port stage: issues word-aligned cache requests with lane-aligned store data and
// registers results for WB. MEM_LoadType = {sign, size[1:0], left_or_right}; define DPORT_ALIGN_CHECK_EN to trap misaligned accesses.
module dmem_port_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        MEM_Valid,
    input  logic        MEM_IsLoad,
    input  logic        MEM_IsStore,
    input  logic [31:0] MEM_ALUOut,
    input  logic [3:0]  MEM_LoadType,
    input  logic [1:0]  MEM_StoreSize,
    input  logic [1:0]  MEM_StoreLR,
    input  logic [31:0] MEM_RtData,
    input  logic        MEM_Flush,
    input  logic        WB_Stall,
    output logic        MEM_Busy,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic        dreq_wr,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_wstrb,
    output logic [31:0] dreq_wdata,
    input  logic        dresp_valid,
    input  logic [31:0] dresp_rdata,
    output logic        WB_Valid,
    output logic        WB_AddrErr,
    output logic [31:0] WB_DMOut,
    output logic [31:0] WB_ALUOut,
    output logic [31:0] WB_RtData,
    output logic [3:0]  WB_LoadType
);
    // state | meaning
    // IDLE  | ready to accept from MEM
    // REQ   | cache request presented, waiting for dreq_ready
    // WAIT  | load issued, waiting for dresp_valid
    // HOLD  | result buffered while WB stalls
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic        kill;
    logic        is_store_q;
    logic [31:0] alu_q;
    logic [31:0] rt_q;
    logic [3:0]  lt_q;
    logic [31:0] hold_dm;

    logic [1:0]  a;
    logic        is_mem;
    logic        accept;
    logic        misalign;
    logic [3:0]  lane_strb;
    logic [31:0] lane_data;
    logic        done_now;
    logic [31:0] done_data;
    logic        kill_eff;

    assign a        = MEM_ALUOut[1:0];
    assign is_mem   = MEM_IsLoad || MEM_IsStore;
    assign accept   = (state == IDLE) && MEM_Valid && !WB_Stall && !MEM_Flush;
    assign MEM_Busy = (state != IDLE) || WB_Stall;
    assign kill_eff = kill || MEM_Flush;

`ifdef DPORT_ALIGN_CHECK_EN
    logic half_acc;
    logic word_acc;
    assign half_acc = MEM_IsLoad ? (MEM_LoadType[2:1] == 2'b01) : (MEM_StoreSize == 2'b01);
    assign word_acc = MEM_IsLoad ? (MEM_LoadType[2:1] == 2'b10)
                                 : (MEM_StoreSize == 2'b10 && MEM_StoreLR == 2'b00);
    assign misalign = is_mem && ((half_acc && a[0]) || (word_acc && a != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        lane_strb = 4'b1111;
        lane_data = MEM_RtData;
        if (MEM_IsLoad) begin
            lane_data = 32'h0;
        end else if (MEM_StoreLR == 2'b10) begin
            // SWL writes the high-order bytes of rt into the low lanes up to a
            lane_strb = 4'b1111 >> (2'd3 - a);
            lane_data = MEM_RtData >> {(2'd3 - a), 3'b000};
        end else if (MEM_StoreLR == 2'b01) begin
            lane_strb = 4'b1111 << a;
            lane_data = MEM_RtData << {a, 3'b000};
        end else begin
            case (MEM_StoreSize)
                2'b00: begin
                    lane_strb = 4'b0001 << a;
                    lane_data = {4{MEM_RtData[7:0]}};
                end
                2'b01: begin
                    lane_strb = a[1] ? 4'b1100 : 4'b0011;
                    lane_data = {2{MEM_RtData[15:0]}};
                end
                default: begin
                    lane_strb = 4'b1111;
                    lane_data = MEM_RtData;
                end
            endcase
        end
    end

    always_comb begin
        done_now  = ((state == REQ) && dreq_ready && is_store_q) || ((state == WAIT) && dresp_valid);
        done_data = (state == WAIT) ? dresp_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            kill        <= 1'b0;
            is_store_q  <= 1'b0;
            alu_q       <= 32'h0;
            rt_q        <= 32'h0;
            lt_q        <= 4'h0;
            hold_dm     <= 32'h0;
            dreq_valid  <= 1'b0;
            dreq_wr     <= 1'b0;
            dreq_addr   <= 32'h0;
            dreq_wstrb  <= 4'h0;
            dreq_wdata  <= 32'h0;
            WB_Valid    <= 1'b0;
            WB_AddrErr  <= 1'b0;
            WB_DMOut    <= 32'h0;
            WB_ALUOut   <= 32'h0;
            WB_RtData   <= 32'h0;
            WB_LoadType <= 4'h0;
        end else begin
            if (!WB_Stall) WB_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mem && !misalign) begin
                        is_store_q <= MEM_IsStore;
                        alu_q      <= MEM_ALUOut;
                        rt_q       <= MEM_RtData;
                        lt_q       <= MEM_LoadType;
                        kill       <= 1'b0;
                        dreq_valid <= 1'b1;
                        dreq_wr    <= MEM_IsStore;
                        dreq_addr  <= {MEM_ALUOut[31:2], 2'b00};
                        dreq_wstrb <= lane_strb;
                        dreq_wdata <= lane_data;
                        state      <= REQ;
                    end else if (accept) begin
                        WB_Valid    <= 1'b1;
                        WB_AddrErr  <= misalign;
                        WB_DMOut    <= 32'h0;
                        WB_ALUOut   <= MEM_ALUOut;
                        WB_RtData   <= MEM_RtData;
                        WB_LoadType <= MEM_LoadType;
                    end
                end
                REQ: begin
                    if (MEM_Flush) kill <= 1'b1;
                    if (dreq_ready) begin
                        dreq_valid <= 1'b0;
                        if (!is_store_q) state <= WAIT;
                    end
                end
                WAIT: begin
                    if (MEM_Flush) kill <= 1'b1;
                end
                HOLD: begin
                    if (MEM_Flush) kill <= 1'b1;
                    if (!WB_Stall) begin
                        WB_Valid    <= !kill_eff;
                        WB_AddrErr  <= 1'b0;
                        WB_DMOut    <= hold_dm;
                        WB_ALUOut   <= alu_q;
                        WB_RtData   <= rt_q;
                        WB_LoadType <= lt_q;
                        kill        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // completion overrides the per-state updates above
            if (done_now) begin
                if (!WB_Stall) begin
                    WB_Valid    <= !kill_eff;
                    WB_AddrErr  <= 1'b0;
                    WB_DMOut    <= done_data;
                    WB_ALUOut   <= alu_q;
                    WB_RtData   <= rt_q;
                    WB_LoadType <= lt_q;
                    kill        <= 1'b0;
                    state       <= IDLE;
                end else begin
                    hold_dm <= done_data;
                    state   <= HOLD;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_stage.sv
// Scoreboard bench for dmem_port_stage: expected cache requests and WB results are queued at stimulus
// time and compared by negedge monitors; scenario tasks add inline timing checks.
module tb_dmem_port_stage;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        MEM_Valid = 1'b0, MEM_IsLoad = 1'b0, MEM_IsStore = 1'b0;
    logic [31:0] MEM_ALUOut = 32'h0;
    logic [3:0]  MEM_LoadType = 4'h0;
    logic [1:0]  MEM_StoreSize = 2'b00, MEM_StoreLR = 2'b00;
    logic [31:0] MEM_RtData = 32'h0;
    logic        MEM_Flush = 1'b0, WB_Stall = 1'b0;
    logic        MEM_Busy, dreq_valid, dreq_wr;
    logic        dreq_ready = 1'b0;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        dresp_valid = 1'b0;
    logic [31:0] dresp_rdata = 32'h0;
    logic        WB_Valid, WB_AddrErr;
    logic [31:0] WB_DMOut, WB_ALUOut, WB_RtData;
    logic [3:0]  WB_LoadType;

    dmem_port_stage dut (
        .clk(clk), .resetn(resetn), .MEM_Valid(MEM_Valid), .MEM_IsLoad(MEM_IsLoad),
        .MEM_IsStore(MEM_IsStore), .MEM_ALUOut(MEM_ALUOut), .MEM_LoadType(MEM_LoadType),
        .MEM_StoreSize(MEM_StoreSize), .MEM_StoreLR(MEM_StoreLR), .MEM_RtData(MEM_RtData),
        .MEM_Flush(MEM_Flush), .WB_Stall(WB_Stall), .MEM_Busy(MEM_Busy),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_wr(dreq_wr),
        .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .WB_Valid(WB_Valid),
        .WB_AddrErr(WB_AddrErr), .WB_DMOut(WB_DMOut), .WB_ALUOut(WB_ALUOut),
        .WB_RtData(WB_RtData), .WB_LoadType(WB_LoadType)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dm, alu, rt;
        logic [3:0]  lt;
        logic        err;
    } wb_exp_t;
    typedef struct {
        logic [31:0] addr, data;
        logic        wr;
        logic [3:0]  strb;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void push_wb(input logic [31:0] dm, alu, rt, input logic [3:0] lt, input logic err);
        wb_exp_t e;
        e.dm = dm; e.alu = alu; e.rt = rt; e.lt = lt; e.err = err;
        wb_q.push_back(e);
    endfunction

    function automatic void push_req(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                                     input logic [31:0] data);
        req_exp_t r;
        r.addr = addr; r.wr = wr; r.strb = strb; r.data = data;
        req_q.push_back(r);
    endfunction

    // WB results are consumed when valid and not stalled
    always @(negedge clk) begin
        wb_exp_t  e;
        req_exp_t r;
        if (resetn && WB_Valid && !WB_Stall) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got dm=%h alu=%h, no result expected", WB_DMOut, WB_ALUOut);
            end else begin
                e = wb_q.pop_front();
                if ({WB_DMOut, WB_ALUOut, WB_RtData, WB_LoadType, WB_AddrErr} !==
                    {e.dm, e.alu, e.rt, e.lt, e.err}) begin
                    errors++;
                    $display("FAIL wb_result got dm=%h alu=%h rt=%h lt=%h err=%b want dm=%h alu=%h rt=%h lt=%h err=%b",
                             WB_DMOut, WB_ALUOut, WB_RtData, WB_LoadType, WB_AddrErr,
                             e.dm, e.alu, e.rt, e.lt, e.err);
                end
            end
        end
        if (resetn && dreq_valid && dreq_ready) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected got addr=%h, no request expected", dreq_addr);
            end else begin
                r = req_q.pop_front();
                if ({dreq_addr, dreq_wr, dreq_wstrb, dreq_wdata} !== {r.addr, r.wr, r.strb, r.data}) begin
                    errors++;
                    $display("FAIL req_fields got addr=%h wr=%b strb=%b data=%h want addr=%h wr=%b strb=%b data=%h",
                             dreq_addr, dreq_wr, dreq_wstrb, dreq_wdata, r.addr, r.wr, r.strb, r.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic ld, st, input logic [31:0] addr, input logic [3:0] lt,
                               input logic [1:0] ss, slr, input logic [31:0] rt);
        MEM_Valid = 1'b1; MEM_IsLoad = ld; MEM_IsStore = st; MEM_ALUOut = addr;
        MEM_LoadType = lt; MEM_StoreSize = ss; MEM_StoreLR = slr; MEM_RtData = rt;
    endtask

    task automatic clear_instr();
        MEM_Valid = 1'b0; MEM_IsLoad = 1'b0; MEM_IsStore = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        checks++;
        if (dreq_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dreq_valid got %b want 0", dreq_valid);
        end
        checks++;
        if (MEM_Busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", MEM_Busy);
        end
        checks++;
        if ({WB_Valid, WB_AddrErr, WB_DMOut, WB_ALUOut, WB_RtData, WB_LoadType} !== 102'h0) begin
            errors++;
            $display("FAIL reset_wb got valid=%b err=%b dm=%h alu=%h rt=%h lt=%h want all 0",
                     WB_Valid, WB_AddrErr, WB_DMOut, WB_ALUOut, WB_RtData, WB_LoadType);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_nonmem();
        push_wb(32'h0, 32'h0000_1234, 32'h0000_0055, 4'h3, 1'b0);
        drive_instr(1'b0, 1'b0, 32'h0000_1234, 4'h3, 2'b00, 2'b00, 32'h0000_0055);
        tick();
        clear_instr();
        checks++;
        if ({WB_Valid, dreq_valid} !== 2'b10) begin
            errors++; $display("FAIL nonmem_timing got valid=%b dreq=%b want 1 0", WB_Valid, dreq_valid);
        end
        tick();
    endtask

    task automatic test_load_word();
        push_req(32'h1000_0004, 1'b0, 4'b1111, 32'h0);
        push_wb(32'hDEAD_BEEF, 32'h1000_0004, 32'h0000_0077, 4'b0100, 1'b0);
        dreq_ready = 1'b1;
        drive_instr(1'b1, 1'b0, 32'h1000_0004, 4'b0100, 2'b00, 2'b00, 32'h0000_0077);
        tick();
        clear_instr();
        checks++;
        if ({dreq_valid, dreq_addr} !== {1'b1, 32'h1000_0004}) begin
            errors++; $display("FAIL lw_req got valid=%b addr=%h want 1 10000004", dreq_valid, dreq_addr);
        end
        tick();
        dreq_ready = 1'b0;
        dresp_valid = 1'b1; dresp_rdata = 32'hDEAD_BEEF;
        checks++;
        if (WB_Valid !== 1'b0) begin
            errors++; $display("FAIL lw_early_valid got %b want 0", WB_Valid);
        end
        tick();
        dresp_valid = 1'b0;
        checks++;
        if (WB_Valid !== 1'b1) begin
            errors++; $display("FAIL lw_latency got valid=%b want 1 three cycles after accept", WB_Valid);
        end
        tick();
    endtask

    task automatic store_case(input logic [1:0] ss, slr, input logic [31:0] addr, rt,
                              input logic [3:0] exp_strb, input logic [31:0] exp_data);
        push_req({addr[31:2], 2'b00}, 1'b1, exp_strb, exp_data);
        push_wb(32'h0, addr, rt, 4'h0, 1'b0);
        dreq_ready = 1'b1;
        drive_instr(1'b0, 1'b1, addr, 4'h0, ss, slr, rt);
        tick();
        clear_instr();
        checks++;
        if ({dreq_valid, dreq_wr} !== 2'b11) begin
            errors++; $display("FAIL store_req addr=%h got valid=%b wr=%b want 1 1", addr, dreq_valid, dreq_wr);
        end
        tick();
        dreq_ready = 1'b0;
        checks++;
        if ({WB_Valid, dreq_valid} !== 2'b10) begin
            errors++; $display("FAIL store_latency addr=%h got valid=%b dreq=%b want 1 0", addr, WB_Valid, dreq_valid);
        end
        tick();
    endtask

    task automatic test_swl_sweep();
        logic [3:0]  s[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        logic [31:0] d[4] = '{32'h0000_0011, 32'h0000_1122, 32'h0011_2233, 32'h1122_3344};
        for (int i = 0; i < 4; i++)
            store_case(2'b10, 2'b10, 32'h0000_4000 + i, 32'h1122_3344, s[i], d[i]);
    endtask

    task automatic test_swr_sb_sh();
        store_case(2'b10, 2'b01, 32'h0000_5001, 32'h1122_3344, 4'b1110, 32'h2233_4400);
        store_case(2'b00, 2'b00, 32'h0000_5002, 32'h1122_3344, 4'b0100, 32'h4444_4444);
        store_case(2'b01, 2'b00, 32'h0000_5002, 32'h1122_3344, 4'b1100, 32'h3344_3344);
        store_case(2'b10, 2'b00, 32'h0000_5000, 32'h1122_3344, 4'b1111, 32'h1122_3344);
    endtask

    task automatic test_stall();
        push_req(32'h2000_0008, 1'b0, 4'b1111, 32'h0);
        push_wb(32'hCAFE_F00D, 32'h2000_0008, 32'h0000_0099, 4'b0100, 1'b0);
        dreq_ready = 1'b0;
        drive_instr(1'b1, 1'b0, 32'h2000_0008, 4'b0100, 2'b00, 2'b00, 32'h0000_0099);
        tick();
        clear_instr();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) dreq_ready = 1'b1;
            checks++;
            if ({dreq_valid, dreq_wr, dreq_addr, dreq_wstrb, dreq_wdata, MEM_Busy} !==
                {1'b1, 1'b0, 32'h2000_0008, 4'b1111, 32'h0, 1'b1}) begin
                errors++;
                $display("FAIL stall_req_stable cycle %0d got valid=%b addr=%h strb=%b data=%h busy=%b want 1 20000008 1111 0 1",
                         i, dreq_valid, dreq_addr, dreq_wstrb, dreq_wdata, MEM_Busy);
            end
            tick();
        end
        dreq_ready = 1'b0;
        dresp_valid = 1'b1; dresp_rdata = 32'hCAFE_F00D;
        WB_Stall = 1'b1;
        tick();
        dresp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) WB_Stall = 1'b0;
            checks++;
            if ({WB_Valid, MEM_Busy} !== 2'b01) begin
                errors++; $display("FAIL stall_hold cycle %0d got valid=%b busy=%b want 0 1", i, WB_Valid, MEM_Busy);
            end
            tick();
        end
        checks++;
        if ({WB_Valid, MEM_Busy} !== 2'b10) begin
            errors++; $display("FAIL stall_release got valid=%b busy=%b want 1 0", WB_Valid, MEM_Busy);
        end
        tick();
    endtask

    task automatic test_flush();
        push_req(32'h3000_0010, 1'b0, 4'b1111, 32'h0);
        dreq_ready = 1'b1;
        drive_instr(1'b1, 1'b0, 32'h3000_0010, 4'b0100, 2'b00, 2'b00, 32'h0000_0011);
        tick();
        clear_instr();
        tick();
        dreq_ready = 1'b0;
        MEM_Flush = 1'b1;
        tick();
        MEM_Flush = 1'b0;
        dresp_valid = 1'b1; dresp_rdata = 32'h1234_5678;
        tick();
        dresp_valid = 1'b0;
        checks++;
        if ({WB_Valid, MEM_Busy} !== 2'b00) begin
            errors++; $display("FAIL flush_killed got valid=%b busy=%b want 0 0", WB_Valid, MEM_Busy);
        end
        push_wb(32'h0, 32'h0000_0ABC, 32'h0000_0022, 4'h0, 1'b0);
        drive_instr(1'b0, 1'b0, 32'h0000_0ABC, 4'h0, 2'b00, 2'b00, 32'h0000_0022);
        tick();
        clear_instr();
        checks++;
        if (WB_Valid !== 1'b1) begin
            errors++; $display("FAIL flush_next_accept got valid=%b want 1", WB_Valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        push_req(32'h4000_0000, 1'b0, 4'b1111, 32'h0);
        dreq_ready = 1'b1;
        drive_instr(1'b1, 1'b0, 32'h4000_0000, 4'b0100, 2'b00, 2'b00, 32'h0);
        tick();
        clear_instr();
        tick();
        dreq_ready = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if ({dreq_valid, MEM_Busy} !== 2'b00) begin
            errors++; $display("FAIL reset_mid got dreq=%b busy=%b want 0 0", dreq_valid, MEM_Busy);
        end
        tick();
        resetn = 1'b1;
        dresp_valid = 1'b1; dresp_rdata = 32'hBAD0_BAD0;
        tick();
        dresp_valid = 1'b0;
        checks++;
        if ({WB_Valid, MEM_Busy} !== 2'b00) begin
            errors++; $display("FAIL reset_drop_resp got valid=%b busy=%b want 0 0", WB_Valid, MEM_Busy);
        end
        tick();
    endtask

    task automatic test_align();
`ifdef DPORT_ALIGN_CHECK_EN
        push_wb(32'h0, 32'h5000_0002, 32'h0000_0033, 4'b0100, 1'b1);
        drive_instr(1'b1, 1'b0, 32'h5000_0002, 4'b0100, 2'b00, 2'b00, 32'h0000_0033);
        tick();
        clear_instr();
        checks++;
        if ({dreq_valid, WB_Valid, WB_AddrErr} !== 3'b011) begin
            errors++;
            $display("FAIL align_trap got dreq=%b valid=%b err=%b want 0 1 1", dreq_valid, WB_Valid, WB_AddrErr);
        end
        tick();
`else
        push_req(32'h5000_0000, 1'b0, 4'b1111, 32'h0);
        push_wb(32'h0BAD_F00D, 32'h5000_0002, 32'h0000_0033, 4'b0100, 1'b0);
        dreq_ready = 1'b1;
        drive_instr(1'b1, 1'b0, 32'h5000_0002, 4'b0100, 2'b00, 2'b00, 32'h0000_0033);
        tick();
        clear_instr();
        checks++;
        if ({dreq_valid, dreq_addr} !== {1'b1, 32'h5000_0000}) begin
            errors++; $display("FAIL align_issue got valid=%b addr=%h want 1 50000000", dreq_valid, dreq_addr);
        end
        tick();
        dreq_ready = 1'b0;
        dresp_valid = 1'b1; dresp_rdata = 32'h0BAD_F00D;
        tick();
        dresp_valid = 1'b0;
        checks++;
        if ({WB_Valid, WB_AddrErr} !== 2'b10) begin
            errors++; $display("FAIL align_retire got valid=%b err=%b want 1 0", WB_Valid, WB_AddrErr);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_word();
        test_swl_sweep();
        test_swr_sb_sh();
        test_stall();
        test_flush();
        test_reset_mid();
        test_align();
        tick(); tick();
        checks++;
        if (wb_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got wb=%0d req=%0d outstanding want 0 0", wb_q.size(), req_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule

// File: doc/dmem_port_stage.md
# dmem_port_stage

Memory-access stage between the MEM pipeline stage and the WB load extender. Accepts one instruction at a time from MEM, issues word-aligned data-cache requests with byte strobes and lane-aligned store data (SB/SH/SW/SWL/SWR), and waits for load data. Results are registered into the WB-side outputs: raw word, address, load type and rt value. WB then performs byte/half selection and LWL/LWR merging.

## Interface
Parameters: none.

- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- MEM_Valid  in  1  instruction present
- MEM_IsLoad / MEM_IsStore  in  1 each  memory op kind (mutually exclusive)
- MEM_ALUOut  in  32  effective address or ALU result
- MEM_LoadType  in  LoadType  sign, size, LeftOrRight
- MEM_StoreSize  in  2  00 byte, 01 half, 10 word
- MEM_StoreLR  in  2  10 SWL, 01 SWR, 00 normal
- MEM_RtData  in  32  rt register value
- MEM_Flush  in  1  kill instruction in this stage
- WB_Stall  in  1  WB cannot take a new result
- MEM_Busy  out  1  upstream must hold
- dreq_valid  out  1  cache request
- dreq_ready  in  1  cache accepts
- dreq_wr  out  1  1 = store
- dreq_addr  out  32  {addr[31:2],2'b00}
- dreq_wstrb  out  4  byte enables
- dreq_wdata  out  32  lane-aligned store data
- dresp_valid  in  1  load data return
- dresp_rdata  in  32  load word
- WB_Valid, WB_AddrErr  out  1 each
- WB_DMOut, WB_ALUOut, WB_RtData  out  32 each
- WB_LoadType  out  LoadType

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- Accept when `state==IDLE && MEM_Valid && !WB_Stall && !MEM_Flush`. MEM_Busy = `(state!=IDLE) || WB_Stall`.
- Non-memory op accepted: WB registers load next edge, WB_Valid=1, WB_DMOut=0. No request is issued.
- Load or store accepted: latch all inputs, go to REQ.
- REQ: dreq_valid=1. All dreq fields are held stable until dreq_ready; the request is never withdrawn.
  - Store with ready: done.
  - Load with ready: go to WAIT.
- WAIT: on dresp_valid the load is done. dresp_valid outside WAIT is ignored.
- Done with !WB_Stall: write WB registers (WB_DMOut = rdata, or 0 for a store), WB_Valid=1, go to IDLE.
- Done with WB_Stall: buffer the result, go to HOLD. In HOLD, write WB when !WB_Stall, then go to IDLE.
- WB_Stall=1: all WB outputs hold.
- Otherwise, any cycle with no retirement gives WB_Valid=0.
- Store strobes/data (a = addr[1:0]):
  - SB: strobe 1<<a, data {4{rt[7:0]}}.
  - SH: a[1] ? 1100 : 0011, data {2{rt[15:0]}}.
  - SW: 1111, data rt.
  - SWL: a=0 → 0001, {24'b0,rt[31:24]}; a=1 → 0011, {16'b0,rt[31:16]}; a=2 → 0111, {8'b0,rt[31:8]}; a=3 → 1111, rt.
  - SWR: a=0 → 1111, rt; a=1 → 1110, {rt[23:0],8'b0}; a=2 → 1100, {rt[15:0],16'b0}; a=3 → 1000, {rt[7:0],24'b0}.
- Loads: dreq_wr=0, strobe 1111, wdata 0.
- MEM_Flush:
  - In IDLE it blocks acceptance.
  - In REQ/WAIT/HOLD it sets a kill flag. The transaction still completes, but the result retires with WB_Valid=0.
  - A store already in REQ is committed to the cache.

## Timing
- Reset: state IDLE, dreq_valid 0, MEM_Busy 0 (WB_Stall permitting), all WB outputs 0, kill flag 0.
- Non-memory op: accepted at edge N, WB_Valid at N+1.
- Load: accept edge N; REQ cycle N+1; with immediate ready and response at N+2, WB_Valid at N+3.
- Store: accept N; ready in N+1; WB_Valid at N+2.
- Every stall cycle on dreq_ready, dresp_valid or WB_Stall adds exactly one cycle.
- Reset asserted mid-transaction: return to IDLE immediately; any outstanding response is dropped.

## Configuration
- DPORT_ALIGN_CHECK_EN defined:
  - An access is misaligned if it is halfword with addr[0]=1, or a non-LR word with addr[1:0]≠0.
  - A misaligned access issues no request and retires one cycle after acceptance, like a non-memory op, with WB_AddrErr=1.
- Undefined: WB_AddrErr tied 0, and misaligned accesses are issued with the strobes above.

## Test plan
- Load word: addr 0x1000_0004, ready and response 0xDEAD_BEEF immediate → dreq_addr 0x1000_0004, WB_DMOut 0xDEAD_BEEF, WB_Valid 3 cycles after accept.
- SWL sweep with rt=0x1122_3344, a=0..3:
  - a=0 → strobe 0001, data 0x0000_0011
  - a=1 → strobe 0011, data 0x0000_1122
  - a=2 → strobe 0111, data 0x0011_2233
  - a=3 → strobe 1111, data 0x1122_3344
- SWR/SB/SH sweep with the same rt:
  - SWR a=1 → strobe 1110, data 0x2233_4400
  - SB a=2 → strobe 0100, data 0x4444_4444
  - SH a=2 → strobe 1100, data 0x3344_3344
- dreq_ready low 4 cycles, then WB_Stall 2 cycles at response → request fields stable throughout, HOLD entered, WB_Valid only after stall clears, MEM_Busy high throughout.
- MEM_Flush in WAIT for a load → response consumed, WB_Valid stays 0, next instruction accepted the cycle after.
- With DPORT_ALIGN_CHECK_EN, LW at 0x…02 → no dreq_valid, WB_AddrErr=1 and WB_Valid=1 at N+1. Without the macro → request issued at 0x…00.
